// File: rtl/branch_predict_pkg.sv
// Shared definitions for the gshare branch predictor: history width,
// 2-bit counter encodings and the saturating counter update.
package branch_predict_pkg;

  localparam int GHR_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam logic [1:0] CTR_RESET = WNT;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr + 2'b01;
      else           res = ctr;
    end else begin
      if (ctr != SNT) res = ctr - 2'b01;
      else            res = ctr;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table: 2^IDX_W saturating 2-bit counters with one
// combinational read port and one synchronous update port (no bypass).
module branch_pht #(
  parameter int IDX_W = branch_predict_pkg::GHR_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [1:0]       o_rdata,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic             i_taken
);
  import branch_predict_pkg::*;

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] r_cnt [0:DEPTH-1];

  // Reads see the pre-update counter even when the same entry is written this cycle.
  assign o_rdata = r_cnt[i_raddr];

  // Counter array reset and saturating update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= CTR_RESET;
      end
    end else if (i_we) begin
      r_cnt[i_waddr] <= ctr_next(r_cnt[i_waddr], i_taken);
    end
  end

endmodule

// File: rtl/branch_predict.sv
// Gshare direction predictor: speculative/committed global history, D->E
// tracking of each predicted branch, and PHT training at Execute resolve.
module branch_predict #(
  parameter int GHR_W = branch_predict_pkg::GHR_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pcD,
  input  logic        branchD,
  input  logic        stallD,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        branch_takeE,
  output logic        pred_takeD,
  output logic        mispredictE
);
  import branch_predict_pkg::*;

  logic [GHR_W-1:0] r_ghr_spec;
  logic [GHR_W-1:0] r_ghr_commit;
  logic             r_validE;
  logic             r_predE;
  logic [GHR_W-1:0] r_idxE;

  logic [GHR_W-1:0] w_idxD;
  logic [GHR_W-1:0] w_commit_next;
  logic [1:0]       w_ctrD;
  logic             w_resolve;
  logic             w_pc_unused;

  assign w_pc_unused   = ^{pcD[31:GHR_W+2], pcD[1:0]};
  assign w_idxD        = pcD[GHR_W+1:2] ^ r_ghr_spec;
  // A stalled or flushed Execute branch must not train, so it resolves only once.
  assign w_resolve     = r_validE & ~stallE & ~flushE;
  assign w_commit_next = {r_ghr_commit[GHR_W-2:0], branch_takeE};
  assign mispredictE   = r_validE & (r_predE ^ branch_takeE);

  // Decode-stage prediction, gated by branchD
  always_comb begin
    pred_takeD = 1'b0;
    if (branchD) begin
      pred_takeD = w_ctrD[1];
    end else begin
      pred_takeD = 1'b0;
    end
  end

  branch_pht #(.IDX_W(GHR_W)) u_pht (
    .clk     (clk),
    .resetn  (resetn),
    .i_raddr (w_idxD),
    .o_rdata (w_ctrD),
    .i_we    (w_resolve),
    .i_waddr (r_idxE),
    .i_taken (branch_takeE)
  );

  // D->E register; flush wins over stall
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_validE <= 1'b0;
      r_predE  <= 1'b0;
      r_idxE   <= {GHR_W{1'b0}};
    end else if (flushE) begin
      r_validE <= 1'b0;
    end else if (!stallE) begin
      r_validE <= branchD;
      r_predE  <= pred_takeD;
      r_idxE   <= w_idxD;
    end
  end

  // Global histories; mispredict recovery overrides the Decode shift
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ghr_spec   <= {GHR_W{1'b0}};
      r_ghr_commit <= {GHR_W{1'b0}};
    end else begin
      if (w_resolve) begin
        r_ghr_commit <= w_commit_next;
      end
      if (w_resolve && mispredictE) begin
        r_ghr_spec <= w_commit_next;
      end else if (branchD && !stallD) begin
        r_ghr_spec <= {r_ghr_spec[GHR_W-2:0], pred_takeD};
      end
    end
  end

endmodule

// File: tb/tb_branch_predict.sv
// Scoreboard bench for branch_predict: a behavioural gshare model predicts
// outputs and history/counter state each cycle; a negedge monitor compares.
module tb_branch_predict;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic        clk;
  logic        resetn;
  logic [31:0] pcD;
  logic        branchD, stallD, stallE, flushE, branch_takeE;
  logic        pred_takeD, mispredictE;

  branch_predict #(.GHR_W(W)) dut (
    .clk(clk), .resetn(resetn), .pcD(pcD), .branchD(branchD), .stallD(stallD),
    .stallE(stallE), .flushE(flushE), .branch_takeE(branch_takeE),
    .pred_takeD(pred_takeD), .mispredictE(mispredictE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pred; int misp; int spec; int commit; int idx; int cnt;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int n_pass = 0;
  int n_total = 0;

  // model state: counters as plain integers 0..3
  int m_pht [0:255];
  int m_spec, m_commit, m_idxE;
  bit m_valid, m_pred;

  function automatic void chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_spec = 0; m_commit = 0; m_idxE = 0; m_valid = 0; m_pred = 0;
  endfunction

  function automatic int idx_of(input int pc);
    return ((pc >>> 2) & MASK) ^ m_spec;
  endfunction

  function automatic int pc_for(input int idx);
    return ((idx ^ m_spec) & MASK) << 2;
  endfunction

  function automatic bit model_pred();
    return branchD && (m_pht[idx_of(pcD)] >= 2);
  endfunction

  function automatic bit model_misp();
    return m_valid && (m_pred != branch_takeE);
  endfunction

  function automatic void model_update();
    int  idxd, hist;
    bit  p, mp, res;
    idxd = idx_of(pcD);
    p    = model_pred();
    mp   = model_misp();
    res  = m_valid && !stallE && !flushE;
    hist = ((m_commit * 2) + int'(branch_takeE)) & MASK;
    if (res) begin
      if (branch_takeE) m_pht[m_idxE] = (m_pht[m_idxE] == 3) ? 3 : m_pht[m_idxE] + 1;
      else              m_pht[m_idxE] = (m_pht[m_idxE] == 0) ? 0 : m_pht[m_idxE] - 1;
    end
    if (res && mp)                m_spec = hist;
    else if (branchD && !stallD)  m_spec = ((m_spec * 2) + int'(p)) & MASK;
    if (res) m_commit = hist;
    if (flushE) m_valid = 0;
    else if (!stallE) begin
      m_valid = branchD; m_pred = p; m_idxE = idxd;
    end
  endfunction

  task automatic set_in(input int br, input int pc, input int sd, input int se,
                        input int fe, input int tk);
    branchD = 1'(br); pcD = 32'(pc); stallD = 1'(sd); stallE = 1'(se);
    flushE = 1'(fe); branch_takeE = 1'(tk);
  endtask

  task automatic cyc();
    exp_t e;
    if (!resetn) model_reset();
    #1;
    e.pred = int'(model_pred()); e.misp = int'(model_misp());
    e.spec = m_spec; e.commit = m_commit; e.idx = m_idxE; e.cnt = m_pht[m_idxE];
    q.push_back(e);
    @(posedge clk);
    if (resetn) model_update();
    #1;
  endtask

  // monitor: compare DUT against the queued expectation for this cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("pred_takeD", int'(pred_takeD), mon_e.pred);
      chk("mispredictE", int'(mispredictE), mon_e.misp);
      chk("ghr_spec", int'(dut.r_ghr_spec), mon_e.spec);
      chk("ghr_commit", int'(dut.r_ghr_commit), mon_e.commit);
      chk("pht_idxE", int'(dut.u_pht.r_cnt[mon_e.idx]), mon_e.cnt);
    end
  end

  initial begin
    int commit_before;
    resetn = 1'b0;
    set_in(1, 32'h10, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    repeat (3) cyc();

    // first prediction after reset
    resetn = 1'b1;
    set_in(1, 32'h10, 0, 0, 0, 0);
    #1;
    chk("first_pred", int'(pred_takeD), 0);
    chk("first_idx", int'(dut.w_idxD), 4);
    cyc();

    // learn taken at index 4
    set_in(0, 0, 0, 0, 0, 1);
    #1 chk("first_mispredict", int'(mispredictE), 1);
    cyc();
    chk("learn_pht4", int'(dut.u_pht.r_cnt[4]), 2);
    chk("learn_commit", int'(dut.r_ghr_commit), 1);
    chk("recover_spec", int'(dut.r_ghr_spec), 1);
    set_in(1, 32'h14, 0, 0, 0, 0);
    #1 chk("learned_pred", int'(pred_takeD), 1);
    cyc();
    set_in(0, 0, 0, 0, 0, 1);
    cyc();

    // saturation: three more taken resolves at index 4
    for (int i = 0; i < 3; i++) begin
      set_in(1, pc_for(4), 0, 0, 0, 0);
      cyc();
      set_in(0, 0, 0, 0, 0, 1);
      cyc();
    end
    chk("sat_st", int'(dut.u_pht.r_cnt[4]), 3);
    set_in(1, pc_for(4), 0, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0);
    cyc();
    chk("sat_down", int'(dut.u_pht.r_cnt[4]), 2);

    // stall: Execute held three cycles, one update on release
    set_in(1, pc_for(32'h20), 0, 0, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 1, 0, 1);
      cyc();
      chk("stall_hold", int'(dut.u_pht.r_cnt[32'h20]), 1);
    end
    set_in(0, 0, 0, 0, 0, 1);
    cyc();
    chk("stall_release", int'(dut.u_pht.r_cnt[32'h20]), 2);
    set_in(0, 0, 0, 0, 0, 1);
    cyc();
    chk("stall_once", int'(dut.u_pht.r_cnt[32'h20]), 2);

    // flush: branch in Decode dropped on its way into Execute
    commit_before = m_commit;
    set_in(1, pc_for(32'h30), 0, 0, 1, 0);
    cyc();
    chk("flush_validE", int'(dut.r_validE), 0);
    set_in(0, 0, 0, 0, 0, 1);
    #1 chk("flush_nomisp", int'(mispredictE), 0);
    cyc();
    chk("flush_pht", int'(dut.u_pht.r_cnt[32'h30]), 1);
    chk("flush_commit", int'(dut.r_ghr_commit), commit_before);

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      set_in(int'($urandom_range(0, 1)), int'($urandom_range(0, 63)) << 2,
             int'($urandom_range(0, 4) == 0), int'($urandom_range(0, 4) == 0),
             int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 1)));
      cyc();
    end

    resetn = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
